// File: rtl/fft_twiddle_addr_gen.sv
// Butterfly address and twiddle (k, n) sequencer for a radix-2 DIT in-place FFT of runtime size N.
// Emits one registered descriptor per cycle over a valid/ready stream, stage by stage.
module fft_twiddle_addr_gen #(
    parameter int MAX_N       = 32,
    parameter int ADDR_WIDTH  = $clog2(MAX_N),
    parameter int STAGE_WIDTH = $clog2(ADDR_WIDTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADDR_WIDTH:0]    n_cfg,
    output logic                   busy,
    output logic                   cfg_err,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDR_WIDTH-1:0]  addr_a,
    output logic [ADDR_WIDTH-1:0]  addr_b,
    output logic [ADDR_WIDTH-1:0]  tw_k,
    output logic [ADDR_WIDTH:0]    tw_n,
    output logic [STAGE_WIDTH-1:0] stage,
    output logic                   last_bfly,
    output logic                   done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  addr_a;
        logic [ADDR_WIDTH-1:0]  addr_b;
        logic [ADDR_WIDTH-1:0]  tw_k;
        logic [ADDR_WIDTH:0]    tw_n;
        logic [STAGE_WIDTH-1:0] stage;
        logic                   last_bfly;
    } desc_t;

    localparam logic [ADDR_WIDTH:0]    N_ONE = 1;
    localparam logic [ADDR_WIDTH-1:0]  A_ONE = 1;
    localparam logic [STAGE_WIDTH-1:0] S_ONE = 1;

    state_e                 state_q, state_d;
    desc_t                  desc_q, desc_d;
    logic [ADDR_WIDTH-1:0]  b_q, b_d;
    logic [STAGE_WIDTH-1:0] l_q, l_d;
    logic                   out_valid_q, out_valid_d;
    logic                   busy_q, busy_d;
    logic                   cfg_err_q, cfg_err_d;
    logic                   done_q, done_d;

    logic                   cfg_legal;
    logic [STAGE_WIDTH-1:0] cfg_log2;
    logic [STAGE_WIDTH-1:0] s_nx;
    logic [ADDR_WIDTH-1:0]  b_nx;
    logic                   xfer;

    // Descriptor for butterfly b of stage s: half = 2^s, pos = b mod half, grp = b / half.
    function automatic desc_t make_desc(
        input logic [STAGE_WIDTH-1:0] s,
        input logic [ADDR_WIDTH-1:0]  b,
        input logic [STAGE_WIDTH-1:0] l,
        input logic [ADDR_WIDTH:0]    n
    );
        desc_t                 d;
        logic [ADDR_WIDTH-1:0] half;
        logic [ADDR_WIDTH-1:0] pos;
        logic [ADDR_WIDTH-1:0] grp;
        half        = A_ONE << s;
        pos         = b & (half - A_ONE);
        grp         = b >> s;
        d.addr_a    = (grp << (s + S_ONE)) | pos;
        d.addr_b    = d.addr_a + half;
        d.tw_k      = pos << (l - S_ONE - s);
        d.tw_n      = n;
        d.stage     = s;
        d.last_bfly = (b == ADDR_WIDTH'(n >> 1) - A_ONE);
        return d;
    endfunction

    // Legal sizes are exactly the powers of two 2..MAX_N; the matching exponent is L.
    always_comb begin
        cfg_legal = 1'b0;
        cfg_log2  = '0;
        for (int i = 1; i <= ADDR_WIDTH; i++) begin
            if (n_cfg == (N_ONE << i)) begin
                cfg_legal = 1'b1;
                cfg_log2  = STAGE_WIDTH'(i);
            end
        end
    end

    assign xfer = out_valid_q && out_ready;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        desc_d      = desc_q;
        b_d         = b_q;
        l_d         = l_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        cfg_err_d   = 1'b0;
        done_d      = 1'b0;
        s_nx        = desc_q.stage;
        b_nx        = b_q + A_ONE;

        unique case (state_q)
            ST_IDLE: begin
                if (start && cfg_legal) begin
                    state_d     = ST_RUN;
                    l_d         = cfg_log2;
                    b_d         = '0;
                    desc_d      = make_desc('0, '0, cfg_log2, n_cfg);
                    out_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end else if (start) begin
                    cfg_err_d = 1'b1;
                end
            end

            ST_RUN: begin
                if (xfer) begin
                    if (desc_q.last_bfly) begin
                        s_nx = desc_q.stage + S_ONE;
                        b_nx = '0;
                    end
                    if (desc_q.last_bfly && (desc_q.stage == l_q - S_ONE)) begin
                        state_d     = ST_DONE;
                        desc_d      = '0;
                        b_d         = '0;
                        out_valid_d = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        b_d    = b_nx;
                        desc_d = make_desc(s_nx, b_nx, l_q, desc_q.tw_n);
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                l_d     = '0;
            end

            default: begin
                state_d     = ST_IDLE;
                desc_d      = '0;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            desc_q      <= '0;
            b_q         <= '0;
            l_q         <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            desc_q      <= desc_d;
            b_q         <= b_d;
            l_q         <= l_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            cfg_err_q   <= cfg_err_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign cfg_err   = cfg_err_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;
    assign addr_a    = desc_q.addr_a;
    assign addr_b    = desc_q.addr_b;
    assign tw_k      = desc_q.tw_k;
    assign tw_n      = desc_q.tw_n;
    assign stage     = desc_q.stage;
    assign last_bfly = desc_q.last_bfly;

endmodule

// File: tb/tb_fft_twiddle_addr_gen.sv
// Directed bench for fft_twiddle_addr_gen: a loop-nest model of the in-place DIT butterfly order
// is compared against the DUT stream on every falling edge.
module tb_fft_twiddle_addr_gen;

    localparam int MAX_N = 32;
    localparam int AW    = 5;
    localparam int SW    = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW:0]   n_cfg;
    logic          busy, cfg_err, out_valid, out_ready;
    logic [AW-1:0] addr_a, addr_b, tw_k;
    logic [AW:0]   tw_n;
    logic [SW-1:0] stage;
    logic          last_bfly, done;

    fft_twiddle_addr_gen #(.MAX_N(MAX_N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n_cfg(n_cfg),
        .busy(busy), .cfg_err(cfg_err), .out_valid(out_valid), .out_ready(out_ready),
        .addr_a(addr_a), .addr_b(addr_b), .tw_k(tw_k), .tw_n(tw_n),
        .stage(stage), .last_bfly(last_bfly), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int k;
        int st;
        bit last;
    } desc_t;

    desc_t exp_q[$];
    desc_t last_seen;
    int    total = 0;
    int    bad = 0;
    int    xfer_cnt = 0;
    int    hold_cnt = 0;
    int    cur_n = 0;
    bit    model_run = 0;
    int    done_pend = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, req, $time);
        end
    endtask

    // Butterfly order written as the textbook loop nest: stage, group of span 2*half, position.
    function automatic void build_model(input int n);
        int l, half, span, idx;
        desc_t d;
        l = $clog2(n);
        exp_q.delete();
        for (int s = 0; s < l; s++) begin
            half = 1 << s;
            span = 2 * half;
            idx  = 0;
            for (int g = 0; g < n / span; g++) begin
                for (int p = 0; p < half; p++) begin
                    d.a    = g * span + p;
                    d.b    = d.a + half;
                    d.k    = p * (n / span);
                    d.st   = s;
                    d.last = (idx == n / 2 - 1);
                    idx++;
                    exp_q.push_back(d);
                end
            end
        end
    endfunction

    // Compare process: one descriptor per falling edge while the model expects a stream.
    initial begin
        desc_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                // outputs are checked directly by the reset scenarios
            end else if (model_run && exp_q.size() > 0) begin
                e = exp_q[0];
                check("out_valid", 32'(out_valid), 1);
                check("busy_run", 32'(busy), 1);
                check("done_run", 32'(done), 0);
                check("addr_a", 32'(addr_a), e.a);
                check("addr_b", 32'(addr_b), e.b);
                check("tw_k", 32'(tw_k), e.k);
                check("tw_n", 32'(tw_n), cur_n);
                check("stage", 32'(stage), e.st);
                check("last_bfly", 32'(last_bfly), 32'(e.last));
                if (out_valid && addr_a == 4 && stage == 0) hold_cnt++;
                if (out_ready) begin
                    last_seen = exp_q.pop_front();
                    xfer_cnt++;
                    if (exp_q.size() == 0) begin
                        model_run = 0;
                        done_pend = 2;
                    end
                end
            end else if (done_pend == 2) begin
                check("done_pulse", 32'(done), 1);
                check("busy_done", 32'(busy), 1);
                check("valid_done", 32'(out_valid), 0);
                done_pend = 1;
            end else if (done_pend == 1) begin
                check("done_clear", 32'(done), 0);
                check("busy_clear", 32'(busy), 0);
                done_pend = 0;
            end else begin
                check("idle_valid", 32'(out_valid), 0);
                check("idle_done", 32'(done), 0);
            end
        end
    end

    task automatic start_xfer(input int n);
        n_cfg = (AW + 1)'(n);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        build_model(n);
        cur_n     = n;
        xfer_cnt  = 0;
        model_run = 1;
    endtask

    task automatic wait_xfers(input int k);
        for (int i = 0; i < 2000 && xfer_cnt < k; i++) @(posedge clk);
        #1;
        check("wait_xfers_timeout", 32'(xfer_cnt >= k), 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000 && (model_run || done_pend != 0); i++) @(posedge clk);
        #1;
        check("wait_idle_timeout", 32'(model_run || done_pend != 0), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_cfg_err"}, 32'(cfg_err), 0);
        check({tag, "_valid"}, 32'(out_valid), 0);
        check({tag, "_addr_a"}, 32'(addr_a), 0);
        check({tag, "_addr_b"}, 32'(addr_b), 0);
        check({tag, "_tw_k"}, 32'(tw_k), 0);
        check({tag, "_tw_n"}, 32'(tw_n), 0);
        check({tag, "_stage"}, 32'(stage), 0);
        check({tag, "_last"}, 32'(last_bfly), 0);
        check({tag, "_done"}, 32'(done), 0);
    endtask

    task automatic bad_cfg(input int n);
        n_cfg = (AW + 1)'(n);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("cfg_err_pulse", 32'(cfg_err), 1);
        check("cfg_err_busy", 32'(busy), 0);
        check("cfg_err_valid", 32'(out_valid), 0);
        @(posedge clk);
        #1;
        check("cfg_err_clear", 32'(cfg_err), 0);
        check("cfg_err_busy2", 32'(busy), 0);
    endtask

    initial begin
        int lit_a[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
        int lit_b[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
        int lit_k[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

        rst_n = 1'b0;
        start = 1'b0;
        n_cfg = '0;
        out_ready = 1'b1;
        #12;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Pin the model against the hand-derived N=8 sequence.
        build_model(8);
        check("model8_len", 32'(exp_q.size()), 12);
        for (int i = 0; i < 12; i++) begin
            check("model8_a", 32'(exp_q[i].a), 32'(lit_a[i]));
            check("model8_b", 32'(exp_q[i].b), 32'(lit_b[i]));
            check("model8_k", 32'(exp_q[i].k), 32'(lit_k[i]));
            check("model8_last", 32'(exp_q[i].last), 32'(i % 4 == 3));
        end
        exp_q.delete();

        // N=8, full rate.
        start_xfer(8);
        wait_idle();
        check("n8_xfers", 32'(xfer_cnt), 12);

        // N=2: single descriptor.
        start_xfer(2);
        wait_idle();
        check("n2_xfers", 32'(xfer_cnt), 1);
        check("n2_desc_a", 32'(last_seen.a), 0);
        check("n2_desc_b", 32'(last_seen.b), 1);
        check("n2_last", 32'(last_seen.last), 1);

        // N=16 with a 5-cycle stall on the 3rd descriptor.
        hold_cnt = 0;
        start_xfer(16);
        wait_xfers(2);
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_idle();
        check("n16_hold_cycles", 32'(hold_cnt), 6);
        check("n16_xfers", 32'(xfer_cnt), 32);

        // Illegal sizes.
        bad_cfg(12);
        bad_cfg(64);
        bad_cfg(1);

        // N=32 with an ignored start and n_cfg change mid-run.
        start_xfer(32);
        wait_xfers(40);
        n_cfg = 6'd4;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_cfg = 6'd32;
        wait_idle();
        check("n32_xfers", 32'(xfer_cnt), 80);
        check("n32_last_a", 32'(last_seen.a), 15);
        check("n32_last_b", 32'(last_seen.b), 31);
        check("n32_last_k", 32'(last_seen.k), 15);
        check("n32_last_stage", 32'(last_seen.st), 4);

        // Abort by reset after 20 transfers, then a fresh N=4 run.
        start_xfer(32);
        wait_xfers(20);
        rst_n = 1'b0;
        model_run = 0;
        done_pend = 0;
        exp_q.delete();
        #1;
        check_all_zero("abort");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done), 0);
        start_xfer(4);
        check("n4_first_a", 32'(addr_a), 0);
        check("n4_first_b", 32'(addr_b), 1);
        check("n4_first_k", 32'(tw_k), 0);
        wait_idle();
        check("n4_xfers", 32'(xfer_cnt), 4);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
